// File: rtl/dcache_pkg.sv
// Shared widths, address field layout and FSM state type for the L1 data cache.
// Every width below follows from NUM_LINES and LINE_BITS.
package dcache_pkg;

   localparam int NUM_LINES   = 16;
   localparam int LINE_BITS   = 256;
   localparam int WORD_BITS   = 32;
   localparam int WORDS       = LINE_BITS / WORD_BITS;
   localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
   localparam int INDEX_BITS  = $clog2(NUM_LINES);
   localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int WSEL_BITS   = $clog2(WORDS);

   typedef logic [TAG_BITS-1:0]                tag_t;
   typedef logic [INDEX_BITS-1:0]              index_t;
   typedef logic [WSEL_BITS-1:0]               wsel_t;
   typedef logic [WORD_BITS-1:0]               word_t;
   typedef logic [WORDS-1:0][WORD_BITS-1:0]    line_t;

   // Byte address split into tag, line index, word select and byte lane.
   typedef struct packed {
      tag_t                   tag;
      index_t                 index;
      wsel_t                  wsel;
      logic [1:0]             byte_lane;
   } addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WB_REQ,
      ST_WB_GAP,
      ST_RD_REQ,
      ST_RD_FILL
   } state_t;

   function automatic logic [31:0] line_addr(input tag_t tag, input index_t idx);
      return {tag, idx, {OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage for the direct-mapped cache.
// Asynchronous read port; synchronous full-line fill and single-word merge.
module dcache_sram
   import dcache_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  index_t i_rd_idx,
   output tag_t   o_rd_tag,
   output logic   o_rd_valid,
   output logic   o_rd_dirty,
   output line_t  o_rd_line,
   input  index_t i_wr_idx,
   input  logic   i_fill_en,
   input  tag_t   i_fill_tag,
   input  line_t  i_fill_line,
   input  logic   i_word_en,
   input  wsel_t  i_word_sel,
   input  word_t  i_word_data
);

   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   tag_t                 r_tag  [NUM_LINES];
   line_t                r_data [NUM_LINES];

   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_dirty = r_dirty[i_rd_idx];
   assign o_rd_line  = r_data[i_rd_idx];

   // A fill always lands clean; a merged store marks the line for write-back.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (i_fill_en) begin
         r_valid[i_wr_idx] <= 1'b1;
         r_dirty[i_wr_idx] <= 1'b0;
      end else if (i_word_en) begin
         r_dirty[i_wr_idx] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
   always_ff @(posedge clk_i) begin
      if (i_fill_en) begin
         r_tag[i_wr_idx]  <= i_fill_tag;
         r_data[i_wr_idx] <= i_fill_line;
      end else if (i_word_en) begin
         r_data[i_wr_idx][i_word_sel] <= i_word_data;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hit path is combinational; misses run a write-back/refill FSM toward the line memory.
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   input  logic                 cpu_read_i,
   input  logic                 cpu_write_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic                 mem_ack_i,
   input  logic [LINE_BITS-1:0] mem_data_i
);

   state_t r_state;
   logic   r_mem_enable;
   logic   r_mem_write;
   logic [31:0] r_mem_addr;
   line_t  r_mem_data;
   tag_t   r_miss_tag;
   index_t r_miss_idx;

   addr_t  w_req;
   tag_t   w_tag;
   logic   w_valid;
   logic   w_dirty;
   line_t  w_line;
   logic   w_req_any;
   logic   w_idle;
   logic   w_hit;
   logic   w_miss;
   logic   w_fill_en;
   logic   w_word_en;
   index_t w_wr_idx;
   logic   w_unused_lane;

   assign w_req         = addr_t'(cpu_addr_i);
   assign w_unused_lane = ^w_req.byte_lane;

   dcache_sram u_sram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_rd_idx    (w_req.index),
      .o_rd_tag    (w_tag),
      .o_rd_valid  (w_valid),
      .o_rd_dirty  (w_dirty),
      .o_rd_line   (w_line),
      .i_wr_idx    (w_wr_idx),
      .i_fill_en   (w_fill_en),
      .i_fill_tag  (r_miss_tag),
      .i_fill_line (line_t'(mem_data_i)),
      .i_word_en   (w_word_en),
      .i_word_sel  (w_req.wsel),
      .i_word_data (cpu_data_i)
   );

   assign w_req_any = cpu_read_i | cpu_write_i;
   assign w_idle    = (r_state == ST_IDLE);
   assign w_hit     = w_valid && (w_tag == w_req.tag);
   assign w_miss    = w_req_any && !w_hit && w_idle;

   assign cpu_stall_o = w_miss || !w_idle;
   assign cpu_data_o  = (cpu_read_i && w_hit && w_idle) ? w_line[w_req.wsel] : '0;

   // The fill targets the captured miss line; a store miss merges on its replay as a hit.
   assign w_fill_en = (r_state == ST_RD_FILL);
   assign w_word_en = w_idle && cpu_write_i && w_hit;
   assign w_wr_idx  = w_fill_en ? r_miss_idx : w_req.index;

   assign mem_enable_o = r_mem_enable;
   assign mem_write_o  = r_mem_write;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;

   // NOTE: state and memory-side outputs use non-blocking assignments so every reader sees pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= ST_IDLE;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_miss_tag   <= '0;
         r_miss_idx   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_miss) begin
                  r_miss_tag   <= w_req.tag;
                  r_miss_idx   <= w_req.index;
                  r_mem_enable <= 1'b1;
                  if (w_valid && w_dirty) begin
                     r_state     <= ST_WB_REQ;
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= line_addr(w_tag, w_req.index);
                     r_mem_data  <= w_line;
                  end else begin
                     r_state     <= ST_RD_REQ;
                     r_mem_write <= 1'b0;
                     r_mem_addr  <= line_addr(w_req.tag, w_req.index);
                  end
               end
            end
            ST_WB_REQ: begin
               if (mem_ack_i) begin
                  r_state      <= ST_WB_GAP;
                  r_mem_enable <= 1'b0;
                  r_mem_write  <= 1'b0;
               end
            end
            // One enable-low cycle lets the memory return to idle before the refill.
            ST_WB_GAP: begin
               r_state      <= ST_RD_REQ;
               r_mem_enable <= 1'b1;
               r_mem_addr   <= line_addr(r_miss_tag, r_miss_idx);
            end
            ST_RD_REQ: begin
               if (mem_ack_i) begin
                  r_state      <= ST_RD_FILL;
                  r_mem_enable <= 1'b0;
               end
            end
            ST_RD_FILL: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller with a line-memory responder model.
// Loads are checked against a flat word-level memory view; stalls against a residency model.
module tb_dcache_controller;

   localparam int ACK_DELAY   = 10;
   localparam int MEM_LAT     = ACK_DELAY + 1;
   localparam int CLEAN_STALL = MEM_LAT + 2;
   localparam int DIRTY_STALL = 2 * MEM_LAT + 3;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic [31:0]  cpu_addr_i = '0;
   logic [31:0]  cpu_data_i = '0;
   logic         cpu_read_i = 1'b0;
   logic         cpu_write_i = 1'b0;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_ack_i = 1'b0;
   logic [255:0] mem_data_i = '0;

   dcache_controller dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_read_i   (cpu_read_i),
      .cpu_write_i  (cpu_write_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_stall_o  (cpu_stall_o),
      .mem_enable_o (mem_enable_o),
      .mem_write_o  (mem_write_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_ack_i    (mem_ack_i),
      .mem_data_i   (mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // ---------------- reference model ----------------
   logic [31:0]  ref_mem   [int unsigned];
   logic [255:0] mem_store [int unsigned];
   logic [31:0]  res_line  [16];
   bit           res_valid [16];
   bit           res_dirty [16];
   logic [31:0]  exp_q [$];

   function automatic logic [31:0] init_word(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (ref_mem.exists(w)) return ref_mem[w];
      return init_word(w);
   endfunction

   function automatic logic [255:0] store_line(input logic [31:0] la);
      logic [255:0] l;
      if (mem_store.exists(la)) return mem_store[la];
      for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4 * w));
      return l;
   endfunction

   function automatic logic [255:0] ref_line(input logic [31:0] la);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = ref_read(la + 32'(4 * w));
      return l;
   endfunction

   // Which line sits in each slot decides the stall a request must see.
   function automatic int model_access(input logic [31:0] a, input bit wr);
      int          idx;
      logic [31:0] la;
      int          s;
      idx = int'(a[8:5]);
      la  = {a[31:5], 5'b0};
      if (res_valid[idx] && res_line[idx] == la) s = 0;
      else begin
         s = (res_valid[idx] && res_dirty[idx]) ? DIRTY_STALL : CLEAN_STALL;
         res_valid[idx] = 1'b1;
         res_line[idx]  = la;
         res_dirty[idx] = 1'b0;
      end
      if (wr) res_dirty[idx] = 1'b1;
      return s;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
      end
      ref_mem.delete();
      foreach (mem_store[la])
         for (int w = 0; w < 8; w++) ref_mem[la + 32'(4 * w)] = mem_store[la][32*w +: 32];
   endfunction

   // ---------------- memory responder ----------------
   bit           busy = 0;
   int           cnt = 0;
   bit           bad = 0;
   bit           cap_write = 0;
   logic [31:0]  cap_addr = '0;
   logic [255:0] cap_data = '0;
   int           n_rd = 0;
   int           n_wr = 0;
   logic [31:0]  last_rd_addr = '0;
   logic [31:0]  last_wb_addr = '0;
   logic [255:0] last_wb_data = '0;

   always @(negedge clk_i) begin
      mem_data_i = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
      if (!rst_i) begin
         busy      = 0;
         cnt       = 0;
         mem_ack_i = 1'b0;
      end else if (mem_ack_i) begin
         mem_ack_i = 1'b0;
         busy      = 0;
         check("mem enable drop after ack", mem_enable_o, 1'b0);
         if (cap_write) mem_store[cap_addr] = cap_data;
         else mem_data_i = store_line(cap_addr);
      end else if (busy) begin
         if (!mem_enable_o || mem_write_o !== cap_write || mem_addr_o !== cap_addr ||
             (cap_write && mem_data_o !== cap_data)) bad = 1;
         cnt++;
         if (cnt == ACK_DELAY) begin
            mem_ack_i = 1'b1;
            check("mem request stable", bad, 1'b0);
         end
      end else if (mem_enable_o) begin
         busy      = 1;
         cnt       = 0;
         bad       = 0;
         cap_write = mem_write_o;
         cap_addr  = mem_addr_o;
         cap_data  = mem_data_o;
         check("mem addr line aligned", mem_addr_o[4:0], 5'd0);
         if (cap_write) begin
            n_wr++;
            last_wb_addr = cap_addr;
            last_wb_data = cap_data;
         end else begin
            n_rd++;
            last_rd_addr = cap_addr;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk_i) begin
      if (rst_i && cpu_read_i) begin
         if (!cpu_stall_o) begin
            check("scoreboard depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check("load data", cpu_data_o, exp_q.pop_front());
         end else begin
            check("load data zero while stalled", cpu_data_o, 32'd0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d, input string name);
      int stalls;
      int exp_s;
      stalls = 0;
      exp_s  = model_access(a, wr);
      if (wr) ref_mem[{a[31:2], 2'b00}] = d;
      else exp_q.push_back(ref_read(a));
      @(posedge clk_i); #1;
      cpu_addr_i  = a;
      cpu_data_i  = d;
      cpu_read_i  = !wr;
      cpu_write_i = wr;
      @(negedge clk_i);
      while (cpu_stall_o && stalls < 200) begin
         stalls++;
         @(negedge clk_i);
      end
      check({name, " stall cycles"}, stalls, exp_s);
      @(posedge clk_i); #1;
      cpu_read_i  = 1'b0;
      cpu_write_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nr0, nw0, waited;
      logic [22:0] tags [4];
      logic [31:0] a;
      logic [255:0] exp_line;
      tags[0] = 23'h0;
      tags[1] = 23'h1;
      tags[2] = 23'h40_0001;
      tags[3] = 23'h7F_FFFF;
      model_reset();

      repeat (3) @(posedge clk_i);
      #1;
      check("reset stall", cpu_stall_o, 1'b0);
      check("reset mem_enable", mem_enable_o, 1'b0);
      check("reset mem_write", mem_write_o, 1'b0);
      check("reset mem_addr", mem_addr_o, 32'd0);
      check("reset cpu_data", cpu_data_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      nr0 = n_rd; nw0 = n_wr;
      do_req(0, 32'h0000_0040, 32'd0, "cold rd 0x40");
      check("cold rd line reads", n_rd - nr0, 1);
      check("cold rd write-backs", n_wr - nw0, 0);
      check("cold rd mem addr", last_rd_addr, 32'h40);

      nr0 = n_rd; nw0 = n_wr;
      do_req(0, 32'h0000_0044, 32'd0, "hit rd 0x44");
      do_req(1, 32'h0000_0040, 32'hDEAD_BEEF, "wr hit 0x40");
      do_req(0, 32'h0000_0040, 32'd0, "rd back 0x40");
      check("hit path memory traffic", (n_rd - nr0) + (n_wr - nw0), 0);

      nr0 = n_rd; nw0 = n_wr;
      exp_line = ref_line(32'h40);
      do_req(0, 32'h0000_0240, 32'd0, "dirty evict rd 0x240");
      check("evict write-backs", n_wr - nw0, 1);
      check("evict wb addr", last_wb_addr, 32'h40);
      check("evict wb word0", last_wb_data[31:0], 32'hDEAD_BEEF);
      check("evict wb line", last_wb_data, exp_line);
      check("evict refill addr", last_rd_addr, 32'h240);
      check("evict line reads", n_rd - nr0, 1);

      nw0 = n_wr;
      do_req(1, 32'h0000_0480, 32'h1234_5678, "store miss 0x480");
      check("store miss refill addr", last_rd_addr, 32'h480);
      check("store miss write-backs", n_wr - nw0, 0);
      do_req(0, 32'h0000_0480, 32'd0, "rd 0x480");
      do_req(0, 32'h0000_0680, 32'd0, "evict store line");
      check("store line wb addr", last_wb_addr, 32'h480);
      check("store line wb word0", last_wb_data[31:0], 32'h1234_5678);

      // Reset while a refill read is outstanding.
      @(posedge clk_i); #1;
      cpu_addr_i = 32'h0000_1000;
      cpu_read_i = 1'b1;
      waited = 0;
      @(negedge clk_i);
      while (!(mem_enable_o && !mem_write_o) && waited < 50) begin
         waited++;
         @(negedge clk_i);
      end
      check("reset test reached read", mem_enable_o && !mem_write_o, 1'b1);
      repeat (3) @(negedge clk_i);
      #2;
      rst_i      = 1'b0;
      cpu_read_i = 1'b0;
      #1;
      check("mid-reset mem_enable", mem_enable_o, 1'b0);
      check("mid-reset mem_write", mem_write_o, 1'b0);
      check("mid-reset mem_addr", mem_addr_o, 32'd0);
      check("mid-reset stall", cpu_stall_o, 1'b0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
      nr0 = n_rd;
      do_req(0, 32'h0000_0040, 32'd0, "post-reset rd 0x40");
      check("post-reset line reads", n_rd - nr0, 1);
      check("post-reset refill addr", last_rd_addr, 32'h40);

      for (int i = 0; i < 400; i++) begin
         a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
         do_req($urandom_range(0, 9) < 4, a, $urandom(), "random");
      end

      repeat (2) @(negedge clk_i);
      check("scoreboard drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
